shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle controller for the LC-3b SHF datapath (LSHF, RSHFL, RSHFA).
//  It accepts one shift request via valid/ready, iterates a STEP-bit shift per
//  cycle on an internal 16-bit accumulator, and holds the result until it is
//  consumed. It sits between the decode/control stage and the ALU result mux.
//  It bounds shifter depth to STEP bits per cycle instead of a full 15-bit barrel.
// PARAMETERS
//  STEP  4  maximum shift distance applied per SHIFT cycle; legal range 1..15
// PORTS
//  clk        in   1   clock; all state updates on the rising edge
//  reset      in   1   synchronous, active-high reset
//  in_valid   in   1   request present
//  in_ready   out  1   sequencer can accept a request
//  in_data    in   16  operand
//  in_amt     in   4   shift amount 0..15
//  in_op      in   2   00=LSHF, 01=RSHFL, 11=RSHFA, 10=reserved
//  out_valid  out  1   result available
//  out_ready  in   1   consumer takes result
//  out_data   out  16  shifted result
//  busy       out  1   high in SHIFT or DONE
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Reset forces state=IDLE,
//    out_valid=0, out_data=16'h0000, busy=0, and clears acc, rem, and op regs.
//    in_ready=0 while reset is high.
//  - FSM states: IDLE, SHIFT, DONE.
//  - IDLE: in_ready=1. When in_valid&in_ready is high (the accept cycle, "cycle 0"):
//    acc<=in_data, rem<=in_amt, op<=in_op, then go to SHIFT.
//  - SHIFT: step=min(rem,STEP).
//      LSHF:  acc<=acc<<step, zero fill.
//      RSHFL: acc<=acc>>step, zero fill.
//      RSHFA: acc<=acc>>step with acc[15] replicated; the sign equals in_data[15]
//             throughout.
//      reserved op: acc unchanged; rem still counts down.
//    rem<=rem-step. If rem-step==0, go to DONE; otherwise stay in SHIFT.
//  - SHIFT cycle count N = max(1, ceil(in_amt/STEP)). SHIFT occupies cycles 1..N.
//    out_valid is first high in cycle N+1.
//  - in_amt=0: one SHIFT cycle with step=0, so the result equals in_data and
//    out_valid is high in cycle 2 (see CONFIGURATION).
//  - DONE: out_valid=1 and out_data=acc, held stable. When out_valid&out_ready,
//    go to IDLE. out_valid is low from the next cycle.
//  - in_ready=0 in SHIFT and DONE. in_valid is ignored there; no request is
//    queued or overlapped.
//  - out_data is registered. It is valid only while out_valid=1 and keeps its
//    last value otherwise.
//  - Reset mid-SHIFT or mid-DONE aborts the operation; no result is produced.
//  - Amount arithmetic is 4-bit unsigned. rem never underflows because step<=rem.
//  - STEP>=in_amt gives a single SHIFT cycle. STEP=15 makes every op N=1.
// CONFIGURATION
//  SHF_SEQ_ZERO_BYPASS_EN
//   defined:   an accept with in_amt==0 goes directly IDLE->DONE with acc=in_data.
//              out_valid is high in cycle 1 and SHIFT is never entered.
//   undefined: in_amt==0 takes one SHIFT cycle, as in BEHAVIOUR. out_valid is
//              high in cycle 2.
//   Nonzero amounts are identical in both builds.
// TESTING (STEP=4 unless noted)
//  1. RSHFA in_data=16'h8001, amt=15 -> N=4; out_valid high in cycle 5;
//     out_data=16'hFFFF.
//  2. RSHFL in_data=16'h8000, amt=5 -> N=2; out_data=16'h0400 in cycle 3.
//     RSHFA with the same inputs -> 16'hFC00.
//  3. LSHF in_data=16'h0001, amt=9 -> N=3; out_data=16'h0200 in cycle 4.
//     With STEP=1, amt=9 -> N=9 and the same result.
//  4. amt=0, in_data=16'h1234, op=RSHFA -> out_data=16'h1234. out_valid high in
//     cycle 2 without the macro, cycle 1 with SHF_SEQ_ZERO_BYPASS_EN.
//  5. out_ready held low 3 cycles in DONE -> out_valid=1 and out_data stable;
//     in_ready=0; a concurrent in_valid is not accepted. Raising out_ready gives
//     IDLE next cycle with in_ready=1.
//  6. reset pulsed in cycle 2 of an amt=12 op -> next cycle state=IDLE,
//     out_valid=0, out_data=16'h0000. No out_valid follows; in_ready=1 once
//     reset drops.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle controller for the LC-3b SHF datapath
// (LSHF, RSHFL, RSHFA). It accepts one request over valid/ready, shifts a
// 16-bit accumulator by at most STEP bits per cycle and holds the result
// until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, and never while reset is high.
// out_valid is high only in DONE. Once out_valid is high, out_data stays
// stable until the consumer takes the result.
//
// Optional build macro SHF_SEQ_ZERO_BYPASS_EN: when defined, a request with
// a zero amount goes directly from IDLE to DONE and skips the SHIFT cycle.
// The current state is visible on dbg_state (0=IDLE, 1=SHIFT, 2=DONE).
module shift_sequencer #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_amt,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] STEP_W = 4'(STEP);

  localparam logic [1:0] OP_LSHF  = 2'b00;
  localparam logic [1:0] OP_RSHFL = 2'b01;
  localparam logic [1:0] OP_RSHFA = 2'b11;

  state_t      r_state;
  logic [15:0] r_acc;
  logic [3:0]  r_rem;
  logic [1:0]  r_op;
  logic [15:0] r_out_data;

  logic [3:0]  w_step;
  logic [3:0]  w_rem_next;
  logic [15:0] w_acc_next;
  logic        w_bypass;

  // This cycle's shift distance is the smaller of the remaining amount and STEP.
  // Because step never exceeds rem, the remaining amount cannot underflow.
  assign w_step     = (r_rem < STEP_W) ? r_rem : STEP_W;
  assign w_rem_next = r_rem - w_step;

`ifdef SHF_SEQ_ZERO_BYPASS_EN
  assign w_bypass = (in_amt == 4'd0);
`else
  assign w_bypass = 1'b0;
`endif

  // Next accumulator value for one SHIFT cycle. A reserved op leaves it unchanged.
  always_comb begin
    w_acc_next = r_acc;
    case (r_op)
      OP_LSHF:  w_acc_next = r_acc << w_step;
      OP_RSHFL: w_acc_next = r_acc >> w_step;
      OP_RSHFA: w_acc_next = $signed(r_acc) >>> w_step;
      default:  w_acc_next = r_acc;
    endcase
  end

  // Control FSM, datapath registers and the held result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_acc      <= 16'h0000;
      r_rem      <= 4'd0;
      r_op       <= 2'b00;
      r_out_data <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc <= in_data;
            r_rem <= in_amt;
            r_op  <= in_op;
            if (w_bypass) begin
              r_out_data <= in_data;
              r_state    <= S_DONE;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_next;
          r_rem <= w_rem_next;
          if (w_rem_next == 4'd0) begin
            r_out_data <= w_acc_next;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign out_data  = r_out_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed and light random checks of shift_sequencer
// with STEP=4, plus a second instance with STEP=1 for the long-iteration case.
// Expected results come from a reference shift model. They are queued when a
// request is driven and compared when the DUT presents its result.
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic [1:0]  dbg_state;

  logic        s1_in_valid;
  logic        s1_in_ready;
  logic [15:0] s1_in_data;
  logic [3:0]  s1_in_amt;
  logic [1:0]  s1_in_op;
  logic        s1_out_valid;
  logic [15:0] s1_out_data;
  logic        s1_busy;
  logic [1:0]  s1_dbg_state;

  localparam int STEP = 4;
`ifdef SHF_SEQ_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 2;
`endif

  int n_total = 0;
  int n_pass  = 0;
  logic [15:0] exp_q[$];

  shift_sequencer #(.STEP(STEP)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  shift_sequencer #(.STEP(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .in_data(s1_in_data), .in_amt(s1_in_amt), .in_op(s1_in_op),
    .out_valid(s1_out_valid), .out_ready(1'b1), .out_data(s1_out_data),
    .busy(s1_busy), .dbg_state(s1_dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the whole shift applied at once.
  function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] a,
                                        input logic [1:0] o);
    logic [15:0] r;
    case (o)
      2'b00:   r = d << a;
      2'b01:   r = d >> a;
      2'b11:   r = $signed(d) >>> a;
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [3:0] a, input int step);
    if (a == 4'd0) return (step == STEP) ? ZERO_LAT : 2;
    return (int'(a) + step - 1) / step + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Driver: issue one request, wait for the result, optionally hold out_ready low
  // while also presenting an illegal concurrent request, then consume the result.
  task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] a,
                        input logic [1:0] o, input int hold);
    int lat;
    logic [15:0] exp_d;
    logic [15:0] first_d;
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_op    = o;
    exp_q.push_back(model(d, a, o));
    tick();
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 65535);
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_latency(a, STEP)));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    first_d = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
      in_amt   = 4'd1;
      tick();
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_data"}, 32'(out_data), 32'(first_d));
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    if (exp_q.size() != 0) begin
      exp_d = exp_q.pop_front();
      chk({tag, ".data"}, 32'(out_data), 32'(exp_d));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
    chk({tag, ".state_idle"}, 32'(dbg_state), 32'd0);
    chk({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic [3:0]  ra;
    logic [1:0]  ro;
    logic [15:0] rd;
    logic [1:0]  ops[4];
    ops[0] = 2'b00; ops[1] = 2'b01; ops[2] = 2'b11; ops[3] = 2'b10;

    reset = 1'b1; in_valid = 1'b0; in_data = 16'h0; in_amt = 4'd0; in_op = 2'b00;
    out_ready = 1'b0;
    s1_in_valid = 1'b0; s1_in_data = 16'h0; s1_in_amt = 4'd0; s1_in_op = 2'b00;
    tick();
    tick();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'h0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst.in_ready_released", 32'(in_ready), 32'd1);

    run_op("rshfa15", 16'h8001, 4'd15, 2'b11, 0);
    run_op("rshfl5",  16'h8000, 4'd5,  2'b01, 0);
    run_op("rshfa5",  16'h8000, 4'd5,  2'b11, 0);
    run_op("lshf9",   16'h0001, 4'd9,  2'b00, 0);
    run_op("amt0",    16'h1234, 4'd0,  2'b11, 0);
    run_op("hold3",   16'hF0F0, 4'd6,  2'b01, 3);
    run_op("resv",    16'hA5C3, 4'd7,  2'b10, 0);
    run_op("lshf4",   16'h00FF, 4'd4,  2'b00, 0);
    run_op("rshfa0",  16'hC000, 4'd0,  2'b11, 1);

    for (int k = 0; k < 6; k++) begin
      rd = 16'($urandom_range(0, 65535));
      ra = 4'($urandom_range(0, 15));
      ro = ops[$urandom_range(0, 3)];
      run_op($sformatf("rnd%0d", k), rd, ra, ro, $urandom_range(0, 2));
    end

    // STEP=1 instance: amt=9 iterates nine SHIFT cycles.
    @(negedge clk);
    s1_in_valid = 1'b1; s1_in_data = 16'h0001; s1_in_amt = 4'd9; s1_in_op = 2'b00;
    exp_q.push_back(model(16'h0001, 4'd9, 2'b00));
    tick();
    s1_in_valid = 1'b0;
    lat = 1;
    while (!s1_out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("step1.latency", 32'(lat), 32'(exp_latency(4'd9, 1)));
    if (exp_q.size() != 0) chk("step1.data", 32'(s1_out_data), 32'(exp_q.pop_front()));

    // Reset pulsed in cycle 2 of an amt=12 operation aborts it.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h0F0F; in_amt = 4'd12; in_op = 2'b00;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("abort.state", 32'(dbg_state), 32'd0);
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.out_data", 32'(out_data), 32'h0);
    chk("abort.in_ready_in_reset", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort.in_ready", 32'(in_ready), 32'd1);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) lat++;
    end
    chk("abort.no_result", 32'(lat), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
